// File: rtl/sarray_mem_resp_pkg.sv
// Shared width defines plus the types and helpers used by the sarray memory responder.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 128
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 64
`endif
`ifndef SARRAY_LINE_OFFSET
`define SARRAY_LINE_OFFSET 8
`endif

package sarray_mem_resp_pkg;

    localparam int ADDR_W   = `ADDR_WIDTH;
    localparam int LOAD_W   = `SARRAY_LOAD_WIDTH;
    localparam int STORE_W  = `SARRAY_STORE_WIDTH;
    localparam int LINE_OFF = `SARRAY_LINE_OFFSET;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [LOAD_W-1:0]  line_t;
    typedef logic [STORE_W-1:0] store_t;

    // Per-stage bookkeeping for a read travelling through the array pipeline.
    typedef struct packed {
        logic vld;
        logic oor;
    } rd_tag_t;

    // Store data fills the whole line: zero-extended or truncated as needed.
    function automatic line_t fit_store(input store_t d);
        return line_t'(d);
    endfunction

    // Any set bit above the line index makes the address out of range.
    function automatic logic addr_oor(input addr_t a, input int unsigned idx_w);
        return (a >> (LINE_OFF + idx_w)) != '0;
    endfunction

endpackage

// File: rtl/sarray_mem_resp_array.sv
// 1R1W line storage with a registered read and RD_LAT-1 extra output stages.
// Storage is never reset; read-first on a same-line read/write collision.
module sarray_mem_array #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int DATA_W = 128
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data
);

    logic [DATA_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] pipe_reg [RD_LAT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            pipe_reg[0] <= mem_reg[rd_idx];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
        end
    end

    assign rd_data = pipe_reg[RD_LAT-1];

endmodule

// File: rtl/sarray_mem_resp.sv
// Line-addressed memory responder: credit-limited AR channel, in-order R queue,
// always-ready AW channel, and a sticky out-of-range error flag.
module sarray_mem_resp
    import sarray_mem_resp_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int RD_LAT   = 2,
    parameter int RQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sarray_ar_valid_i,
    output logic               sarray_ar_ready_o,
    input  logic [ADDR_W-1:0]  sarray_ar_addr_i,
    output logic               sarray_r_valid_o,
    input  logic               sarray_r_ready_i,
    output logic [LOAD_W-1:0]  sarray_r_data_o,
    input  logic               sarray_aw_valid_i,
    output logic               sarray_aw_ready_o,
    input  logic [ADDR_W-1:0]  sarray_aw_addr_i,
    input  logic [STORE_W-1:0] sarray_aw_data_i,
    output logic               err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(RQ_DEPTH) + 1;
    localparam int PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(RQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RQ_DEPTH - 1);

    logic              ar_ready_reg;
    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  occ_next;
    logic              ar_fire;
    logic              ar_oor;
    logic              aw_fire;
    logic              aw_oor;
    logic              r_valid;
    logic              r_fire;
    rd_tag_t           tag_reg [RD_LAT];
    line_t             arr_rd_data;
    line_t             push_data;
    logic              push;
    line_t             rq_mem [RQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [OCC_W-1:0]  q_cnt_reg;
    logic              err_reg;
    logic              unused_addr_bits;

    assign ar_oor  = addr_oor(sarray_ar_addr_i, IDX_W);
    assign aw_oor  = addr_oor(sarray_aw_addr_i, IDX_W);
    assign ar_fire = sarray_ar_valid_i & ar_ready_reg;
    assign aw_fire = sarray_aw_valid_i;
    assign r_fire  = r_valid & sarray_r_ready_i;

    // Byte offset within a line carries no meaning here.
    assign unused_addr_bits = ^{sarray_ar_addr_i[LINE_OFF-1:0], sarray_aw_addr_i[LINE_OFF-1:0]};

    sarray_mem_array #(
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .DATA_W (LOAD_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (ar_fire & ~ar_oor),
        .rd_idx  (sarray_ar_addr_i[LINE_OFF +: IDX_W]),
        .rd_data (arr_rd_data),
        .wr_en   (aw_fire & ~aw_oor),
        .wr_idx  (sarray_aw_addr_i[LINE_OFF +: IDX_W]),
        .wr_data (fit_store(sarray_aw_data_i))
    );

    // Valid/oor tags shadow the array pipeline so the queue push lands RD_LAT edges after accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= '{vld: ar_fire, oor: ar_oor};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    assign push      = tag_reg[RD_LAT-1].vld;
    assign push_data = tag_reg[RD_LAT-1].oor ? '0 : arr_rd_data;

    always_ff @(posedge clk) begin
        if (push) begin
            rq_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            q_cnt_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (r_fire) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            end
            q_cnt_reg <= q_cnt_reg + OCC_W'(push) - OCC_W'(r_fire);
        end
    end

    assign r_valid = (q_cnt_reg != '0);

    // Credits cover both in-flight reads and queued beats, so the queue can never overflow.
    assign occ_next = occ_reg + OCC_W'(ar_fire) - OCC_W'(r_fire);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_reg      <= '0;
            ar_ready_reg <= 1'b1;
        end else begin
            occ_reg      <= occ_next;
            ar_ready_reg <= (occ_next < OCC_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((ar_fire & ar_oor) | (aw_fire & aw_oor)) begin
            err_reg <= 1'b1;
        end
    end

    assign sarray_ar_ready_o = ar_ready_reg;
    assign sarray_aw_ready_o = 1'b1;
    assign sarray_r_valid_o  = r_valid;
    assign sarray_r_data_o   = r_valid ? rq_mem[rd_ptr_reg] : '0;
    assign err_o             = err_reg;

endmodule

// File: tb/tb_sarray_mem_resp.sv
// Directed bench for sarray_mem_resp: a memory model feeds a scoreboard queue at AR
// handshake, beats are popped and compared as the DUT delivers them.
module tb_sarray_mem_resp;
    import sarray_mem_resp_pkg::*;

    localparam int DEPTH    = 256;
    localparam int RD_LAT   = 2;
    localparam int RQ_DEPTH = 4;

    logic   clk;
    logic   rst_n;
    logic   ar_valid;
    logic   ar_ready;
    addr_t  ar_addr;
    logic   r_valid;
    logic   r_ready;
    line_t  r_data;
    logic   aw_valid;
    logic   aw_ready;
    addr_t  aw_addr;
    store_t aw_data;
    logic   err;

    sarray_mem_resp #(
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .RQ_DEPTH (RQ_DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sarray_ar_valid_i (ar_valid),
        .sarray_ar_ready_o (ar_ready),
        .sarray_ar_addr_i  (ar_addr),
        .sarray_r_valid_o  (r_valid),
        .sarray_r_ready_i  (r_ready),
        .sarray_r_data_o   (r_data),
        .sarray_aw_valid_i (aw_valid),
        .sarray_aw_ready_o (aw_ready),
        .sarray_aw_addr_i  (aw_addr),
        .sarray_aw_data_i  (aw_data),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    line_t model_mem [DEPTH];
    line_t sb [$];
    int    beat_cyc [$];
    line_t beat_dat [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ar_acc = 0;

    task automatic check_line(input string tag, input line_t obs, input line_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic tb_oor(input addr_t a);
        return a >= addr_t'(DEPTH * 256);
    endfunction

    function automatic int tb_idx(input addr_t a);
        return int'((a >> 8) % DEPTH);
    endfunction

    // One clock: log handshakes seen this cycle, then advance to just past the next edge.
    task automatic cycle();
        line_t rd_exp;
        if (rst_n && ar_valid && ar_ready) begin
            rd_exp = tb_oor(ar_addr) ? '0 : model_mem[tb_idx(ar_addr)];
            sb.push_back(rd_exp);
            ar_acc++;
        end
        if (aw_valid && !tb_oor(aw_addr)) begin
            model_mem[tb_idx(aw_addr)] = line_t'(aw_data);
        end
        if (rst_n && r_valid && r_ready) begin
            beat_cyc.push_back(cyc);
            beat_dat.push_back(r_data);
            check_bit("beat_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                check_line("r_data", r_data, sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            cycle();
            n++;
        end
        check_int("drain_done", sb.size(), 0);
    endtask

    task automatic clear_beats();
        beat_cyc.delete();
        beat_dat.delete();
    endtask

    initial begin
        int first_ar;
        int acc0;

        rst_n    = 1'b0;
        ar_valid = 1'b0;
        ar_addr  = '0;
        r_ready  = 1'b0;
        aw_valid = 1'b0;
        aw_addr  = '0;
        aw_data  = '0;
        cycle();
        cycle();
        check_bit("rst_ar_ready", ar_ready, 1'b1);
        check_bit("rst_r_valid", r_valid, 1'b0);
        check_line("rst_r_data", r_data, '0);
        check_bit("rst_err", err, 1'b0);
        check_bit("aw_ready", aw_ready, 1'b1);
        rst_n = 1'b1;
        cycle();

        // Lines 0..3 <- A0..A3, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            aw_valid = 1'b1;
            aw_addr  = addr_t'(i << 8);
            aw_data  = store_t'(32'hA0 + i);
            cycle();
        end
        aw_valid = 1'b0;
        r_ready  = 1'b1;
        clear_beats();
        first_ar = cyc;
        for (int i = 0; i < 4; i++) begin
            ar_valid = 1'b1;
            ar_addr  = addr_t'(i << 8);
            cycle();
        end
        ar_valid = 1'b0;
        drain(20);
        check_int("b2b_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) begin
            // First beat lands RD_LAT edges after the handshake edge (first_ar + 1).
            check_int("b2b_first_lat", beat_cyc[0], first_ar + 1 + RD_LAT);
            for (int i = 1; i < 4; i++) begin
                check_int("b2b_no_gap", beat_cyc[i], beat_cyc[i-1] + 1);
            end
            for (int i = 0; i < 4; i++) begin
                check_line("b2b_data", beat_dat[i], line_t'(32'hA0 + i));
            end
        end

        // Sustained stream: every attempt accepted while r_ready stays high.
        acc0 = ar_acc;
        for (int i = 0; i < 8; i++) begin
            ar_valid = 1'b1;
            ar_addr  = addr_t'((i % 4) << 8);
            cycle();
        end
        ar_valid = 1'b0;
        check_int("stream_accepts", ar_acc - acc0, 8);
        drain(20);

        // Back-pressure: six attempts, only RQ_DEPTH credits.
        r_ready = 1'b0;
        cycle();
        acc0 = ar_acc;
        for (int i = 0; i < 6; i++) begin
            ar_valid = 1'b1;
            ar_addr  = addr_t'((i % 4) << 8);
            cycle();
        end
        ar_valid = 1'b0;
        check_int("bp_accepts", ar_acc - acc0, RQ_DEPTH);
        check_bit("bp_ar_ready_low", ar_ready, 1'b0);
        cycle();
        cycle();
        check_bit("bp_r_valid", r_valid, 1'b1);
        check_line("bp_head", r_data, line_t'(32'hA0));
        cycle();
        check_line("bp_head_held", r_data, line_t'(32'hA0));
        r_ready = 1'b1;
        clear_beats();
        drain(20);
        check_int("bp_drained", beat_dat.size(), 4);
        cycle();
        cycle();
        check_bit("bp_ar_ready_back", ar_ready, 1'b1);
        check_bit("bp_r_valid_low", r_valid, 1'b0);

        // Read-first collision on line 5.
        aw_valid = 1'b1;
        aw_addr  = addr_t'(32'h500);
        aw_data  = store_t'(32'h11);
        cycle();
        aw_data  = store_t'(32'h55);
        ar_valid = 1'b1;
        ar_addr  = addr_t'(32'h500);
        clear_beats();
        cycle();
        aw_valid = 1'b0;
        cycle();
        ar_valid = 1'b0;
        drain(20);
        check_int("rf_beats", beat_dat.size(), 2);
        if (beat_dat.size() == 2) begin
            check_line("rf_old", beat_dat[0], line_t'(32'h11));
            check_line("rf_new", beat_dat[1], line_t'(32'h55));
        end

        // Out-of-range read and write.
        check_bit("oor_err_before", err, 1'b0);
        clear_beats();
        ar_valid = 1'b1;
        ar_addr  = addr_t'(DEPTH << 8);
        cycle();
        ar_valid = 1'b0;
        check_bit("oor_err_set", err, 1'b1);
        drain(20);
        check_int("oor_beats", beat_dat.size(), 1);
        if (beat_dat.size() == 1) begin
            check_line("oor_zero", beat_dat[0], '0);
        end
        aw_valid = 1'b1;
        aw_addr  = addr_t'(DEPTH << 8);
        aw_data  = store_t'(32'hEE);
        cycle();
        aw_valid = 1'b0;
        clear_beats();
        ar_valid = 1'b1;
        ar_addr  = '0;
        cycle();
        ar_valid = 1'b0;
        drain(20);
        check_int("oor_w_beats", beat_dat.size(), 1);
        if (beat_dat.size() == 1) begin
            check_line("oor_w_line0", beat_dat[0], line_t'(32'hA0));
        end
        check_bit("oor_err_sticky", err, 1'b1);

        // Reset with three reads outstanding.
        r_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            ar_valid = 1'b1;
            ar_addr  = addr_t'(i << 8);
            cycle();
        end
        ar_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        sb.delete();
        check_bit("mid_rst_r_valid", r_valid, 1'b0);
        check_bit("mid_rst_err", err, 1'b0);
        check_bit("mid_rst_ar_ready", ar_ready, 1'b1);
        r_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_bit("no_beat_after_rst", r_valid, 1'b0);
        end
        clear_beats();
        ar_valid = 1'b1;
        ar_addr  = addr_t'(32'h200);
        cycle();
        ar_valid = 1'b0;
        drain(20);
        check_int("post_rst_beats", beat_dat.size(), 1);
        if (beat_dat.size() == 1) begin
            check_line("post_rst_mem", beat_dat[0], line_t'(32'hA2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sarray_mem_resp.md
SARRAY_MEM_RESP -- requirements
Module: sarray_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of memory lines (power of two).
REQ-002 SHALL have parameter RD_LAT, default 2, meaning array read latency in cycles, 1..4.
REQ-003 SHALL have parameter RQ_DEPTH, default 4, meaning response-queue entries (power of two, >= RD_LAT).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sarray_ar_valid_i  input  1  read request valid.
REQ-007 SHALL have port sarray_ar_ready_o  output  1  read request accepted.
REQ-008 SHALL have port sarray_ar_addr_i  input  `ADDR_WIDTH  read byte address.
REQ-009 SHALL have port sarray_r_valid_o  output  1  read data valid.
REQ-010 SHALL have port sarray_r_ready_i  input  1  read data consumed.
REQ-011 SHALL have port sarray_r_data_o  output  `SARRAY_LOAD_WIDTH  read data line.
REQ-012 SHALL have port sarray_aw_valid_i  input  1  write request valid (address and data together).
REQ-013 SHALL have port sarray_aw_ready_o  output  1  write accepted.
REQ-014 SHALL have port sarray_aw_addr_i  input  `ADDR_WIDTH  write byte address.
REQ-015 SHALL have port sarray_aw_data_i  input  `SARRAY_STORE_WIDTH  write data.
REQ-016 SHALL have port err_o  output  1  sticky out-of-range access flag.

Function
REQ-017 SHALL address lines in 256-byte units: line index = addr[8 +: log2(DEPTH)]; addr[7:0] ignored.
REQ-018 SHALL treat any address with nonzero bits above bit 8+log2(DEPTH)-1 as out of range.
REQ-019 SHALL complete AR handshake when sarray_ar_valid_i and sarray_ar_ready_o are both high on a clock edge.
REQ-020 SHALL drive sarray_ar_ready_o = 1 iff (in-flight reads + queued responses) < RQ_DEPTH; occupancy counter width log2(RQ_DEPTH)+1.
REQ-021 SHALL deliver accepted read data into the response queue exactly RD_LAT cycles after the AR handshake, in request order.
REQ-022 SHALL drive sarray_r_valid_o = queue not empty and sarray_r_data_o = head entry; pop on sarray_r_valid_o & sarray_r_ready_i.
REQ-023 SHALL hold sarray_r_data_o stable while sarray_r_valid_o=1 and sarray_r_ready_i=0.
REQ-024 SHALL sustain one AR accept and one R pop per cycle when sarray_r_ready_i=1 (no bubbles, queue never overflows).
REQ-025 SHALL allow AR accept in a cycle where occupancy = RQ_DEPTH-1 only if no pop; a same-cycle pop does not free a credit (ready is registered from occupancy).
REQ-026 SHALL return all-zero data for an out-of-range read and set err_o.
REQ-027 SHALL drive sarray_aw_ready_o = 1 constantly; write takes effect at the handshake edge.
REQ-028 SHALL write aw_data zero-extended/truncated to `SARRAY_LOAD_WIDTH into the whole line.
REQ-029 SHALL drop an out-of-range write (memory unchanged) and set err_o.
REQ-030 SHALL be read-first: read and write to the same line in the same cycle returns the old line; subsequent reads return new data.
REQ-031 SHALL keep err_o set until reset.

Reset
REQ-032 SHALL, with rst_n=0 at a clock edge, clear occupancy, read pipeline valids, queue pointers and err_o; outputs sarray_ar_ready_o=1 (after reset), sarray_r_valid_o=0, sarray_r_data_o=0, err_o=0.
REQ-033 SHALL discard in-flight reads and queued responses on reset mid-operation; no R beat for them after reset.
REQ-034 SHALL not reset memory array contents.

Structure
REQ-035 SHALL take `ADDR_WIDTH, `SARRAY_LOAD_WIDTH, `SARRAY_STORE_WIDTH from the shared defines; line-offset constant (8) SHALL be added there as a named define.
REQ-036 SHALL instantiate one sub-module sarray_mem_array (1R1W, RD_LAT-cycle read, no reset on storage); queue and credit logic stay in sarray_mem_resp.

Verification
REQ-037 SHALL cover write lines 0..3 with data 0xA0..0xA3, then AR at 0x000,0x100,0x200,0x300 back-to-back with r_ready=1 -> four R beats 0xA0..0xA3 in order, first RD_LAT cycles after first AR, no gaps.
REQ-038 SHALL cover r_ready=0 with 6 AR attempts -> exactly 4 accepted, ar_ready=0 afterward, r_data held at first beat; releasing r_ready drains 4 beats then ar_ready=1.
REQ-039 SHALL cover same-cycle AW(0x500, 0x55) and AR(0x500) with old value 0x11 -> R returns 0x11; next AR(0x500) returns 0x55.
REQ-040 SHALL cover AR at line DEPTH (0x10000 for DEPTH=256) -> R beat all-zero, err_o=1 sticky; AW there leaves line 0 unchanged.
REQ-041 SHALL cover rst_n=0 for one cycle with 3 reads in flight -> no R beats afterward, r_valid=0, err_o=0, memory data preserved on re-read.
